// File: rtl/cdb_arbiter_if.sv
// Result-producer channels and the shared broadcast bus.
// master drives results, slave is the arbiter.
interface cdb_arbiter_if #(
  parameter int ROB_SIZE_LOG = 4
);
  logic                    alu_send;
  logic [31:0]             alu_value;
  logic [ROB_SIZE_LOG-1:0] alu_reorder;
  logic                    alu_full;
  logic                    lsb_send;
  logic [31:0]             lsb_value;
  logic [ROB_SIZE_LOG-1:0] lsb_reorder;
  logic                    lsb_full;
  logic                    cdb_send;
  logic [31:0]             cdb_value;
  logic [ROB_SIZE_LOG-1:0] cdb_reorder;

  modport master (
    output alu_send, alu_value, alu_reorder,
    output lsb_send, lsb_value, lsb_reorder,
    input  alu_full, lsb_full,
    input  cdb_send, cdb_value, cdb_reorder
  );

  modport slave (
    input  alu_send, alu_value, alu_reorder,
    input  lsb_send, lsb_value, lsb_reorder,
    output alu_full, lsb_full,
    output cdb_send, cdb_value, cdb_reorder
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Two-source result FIFOs drained round-robin
// onto the single common data bus.
module cdb_arbiter #(
  parameter int ROB_SIZE_LOG = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  input logic          jump_rst,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [31:0]             alu_val [FIFO_DEPTH];
  logic [ROB_SIZE_LOG-1:0] alu_tag [FIFO_DEPTH];
  logic [31:0]             lsb_val [FIFO_DEPTH];
  logic [ROB_SIZE_LOG-1:0] lsb_tag [FIFO_DEPTH];

  logic [PW-1:0] alu_head, alu_tail;
  logic [PW-1:0] lsb_head, lsb_tail;
  logic [CW-1:0] alu_cnt, lsb_cnt;
  logic          last_grant;

  logic                    cdb_send_q;
  logic [31:0]             cdb_value_q;
  logic [ROB_SIZE_LOG-1:0] cdb_reorder_q;

  logic run;
  logic alu_push, lsb_push;
  logic alu_ne, lsb_ne;
  logic alu_gnt, lsb_gnt;

  assign run      = rdy & ~jump_rst;
  assign alu_push = run & bus.alu_send;
  assign lsb_push = run & bus.lsb_send;
  assign alu_ne   = (alu_cnt != '0);
  assign lsb_ne   = (lsb_cnt != '0);

  // last_grant=1 means LSB went last, so ALU wins a tie
  assign alu_gnt = alu_ne & (~lsb_ne | last_grant);
  assign lsb_gnt = lsb_ne & (~alu_ne | ~last_grant);

  assign bus.alu_full    = (alu_cnt == FULL);
  assign bus.lsb_full    = (lsb_cnt == FULL);
  assign bus.cdb_send    = cdb_send_q;
  assign bus.cdb_value   = cdb_value_q;
  assign bus.cdb_reorder = cdb_reorder_q;

  // entry storage: written at tail, never needs reset
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_val[alu_tail] <= bus.alu_value;
      alu_tag[alu_tail] <= bus.alu_reorder;
    end
    if (lsb_push) begin
      lsb_val[lsb_tail] <= bus.lsb_value;
      lsb_tag[lsb_tail] <= bus.lsb_reorder;
    end
  end

  // pointers, counts, arbitration and the bus register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_head      <= '0;
      alu_tail      <= '0;
      alu_cnt       <= '0;
      lsb_head      <= '0;
      lsb_tail      <= '0;
      lsb_cnt       <= '0;
      last_grant    <= 1'b1;
      cdb_send_q    <= 1'b0;
      cdb_value_q   <= '0;
      cdb_reorder_q <= '0;
    end else if (jump_rst) begin
      alu_head   <= '0;
      alu_tail   <= '0;
      alu_cnt    <= '0;
      lsb_head   <= '0;
      lsb_tail   <= '0;
      lsb_cnt    <= '0;
      last_grant <= 1'b1;
      cdb_send_q <= 1'b0;
    end else if (!rdy) begin
      cdb_send_q <= 1'b0;
    end else begin
      if (alu_push) alu_tail <= alu_tail + ONE;
      if (lsb_push) lsb_tail <= lsb_tail + ONE;
      if (alu_gnt)  alu_head <= alu_head + ONE;
      if (lsb_gnt)  lsb_head <= lsb_head + ONE;
      alu_cnt <= alu_cnt + CW'(alu_push)
               - CW'(alu_gnt);
      lsb_cnt <= lsb_cnt + CW'(lsb_push)
               - CW'(lsb_gnt);
      unique case (1'b1)
        alu_gnt: begin
          cdb_send_q    <= 1'b1;
          cdb_value_q   <= alu_val[alu_head];
          cdb_reorder_q <= alu_tag[alu_head];
          last_grant    <= 1'b0;
        end
        lsb_gnt: begin
          cdb_send_q    <= 1'b1;
          cdb_value_q   <= lsb_val[lsb_head];
          cdb_reorder_q <= lsb_tag[lsb_head];
          last_grant    <= 1'b1;
        end
        default: cdb_send_q <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, tie order,
// backpressure, stall, flush and async reset.
module tb_cdb_arbiter;
  logic clk;
  logic rst;
  logic rdy;
  logic jump_rst;

  cdb_arbiter_if #(.ROB_SIZE_LOG(4)) bus ();

  cdb_arbiter #(
    .ROB_SIZE_LOG(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .jump_rst(jump_rst),
    .bus(bus)
  );

  int total;
  int bad;
  logic [35:0] bcast [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every broadcast as {tag, value}
  always @(negedge clk)
    if (bus.cdb_send)
      bcast.push_back({bus.cdb_reorder, bus.cdb_value});

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.alu_send    = 1'b0;
    bus.alu_value   = '0;
    bus.alu_reorder = '0;
    bus.lsb_send    = 1'b0;
    bus.lsb_value   = '0;
    bus.lsb_reorder = '0;
  endtask

  task automatic reset_dut();
    idle_in();
    rdy      = 1'b1;
    jump_rst = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alu(input logic [31:0] v,
                     input logic [3:0] t);
    bus.alu_send    = 1'b1;
    bus.alu_value   = v;
    bus.alu_reorder = t;
  endtask

  task automatic lsb(input logic [31:0] v,
                     input logic [3:0] t);
    bus.lsb_send    = 1'b1;
    bus.lsb_value   = v;
    bus.lsb_reorder = t;
  endtask

  task automatic exp_bus(input string tag,
                         input logic s,
                         input logic [31:0] v,
                         input logic [3:0] t);
    chk({tag, "_send"}, 64'(bus.cdb_send), 64'(s));
    if (s) begin
      chk({tag, "_val"}, 64'(bus.cdb_value), 64'(v));
      chk({tag, "_tag"}, 64'(bus.cdb_reorder),
          64'(t));
    end
  endtask

  int base;
  int ai, li, ae, le;
  logic asend, lsend, saw_af, saw_lf;
  logic [35:0] e;

  initial begin
    total = 0;
    bad   = 0;
    idle_in();
    rdy      = 1'b1;
    jump_rst = 1'b0;
    rst      = 1'b1;
    tick();
    chk("rst_send", 64'(bus.cdb_send), 64'd0);
    chk("rst_val", 64'(bus.cdb_value), 64'd0);
    chk("rst_tag", 64'(bus.cdb_reorder), 64'd0);
    chk("rst_afull", 64'(bus.alu_full), 64'd0);
    chk("rst_lfull", 64'(bus.lsb_full), 64'd0);
    rst = 1'b0;

    // single-source latency
    alu(32'h11, 4'd3);
    tick();
    idle_in();
    exp_bus("lat_e1", 1'b0, 32'h0, 4'd0);
    tick();
    exp_bus("lat_e2", 1'b1, 32'h11, 4'd3);
    tick();
    exp_bus("lat_e3", 1'b0, 32'h0, 4'd0);

    // tie and alternation
    reset_dut();
    alu(32'hA1, 4'd1);
    lsb(32'hB1, 4'd2);
    tick();
    alu(32'hA2, 4'd4);
    lsb(32'hB2, 4'd5);
    tick();
    idle_in();
    exp_bus("tie_1", 1'b1, 32'hA1, 4'd1);
    tick();
    exp_bus("tie_2", 1'b1, 32'hB1, 4'd2);
    tick();
    exp_bus("tie_3", 1'b1, 32'hA2, 4'd4);
    tick();
    exp_bus("tie_4", 1'b1, 32'hB2, 4'd5);
    tick();
    exp_bus("tie_end", 1'b0, 32'h0, 4'd0);

    // full backpressure, both producers saturating
    reset_dut();
    base   = bcast.size();
    ai     = 0;
    li     = 0;
    saw_af = 1'b0;
    saw_lf = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (ai >= 10 && li >= 10 &&
          bcast.size() - base >= 20) break;
      asend = (ai < 10) && !bus.alu_full;
      lsend = (li < 10) && !bus.lsb_full;
      bus.alu_send    = asend;
      bus.alu_value   = 32'hA000_0000 + ai;
      bus.alu_reorder = 4'(ai);
      bus.lsb_send    = lsend;
      bus.lsb_value   = 32'hB000_0000 + li;
      bus.lsb_reorder = 4'(li);
      tick();
      if (asend) ai++;
      if (lsend) li++;
      if (bus.alu_full) saw_af = 1'b1;
      if (bus.lsb_full) saw_lf = 1'b1;
    end
    idle_in();
    repeat (3) tick();
    chk("bp_afull_seen", 64'(saw_af), 64'd1);
    chk("bp_lfull_seen", 64'(saw_lf), 64'd1);
    chk("bp_count", 64'(bcast.size() - base), 64'd20);
    ae = 0;
    le = 0;
    for (int k = base; k < bcast.size(); k++) begin
      e = bcast[k];
      if (e[31:28] == 4'hA) begin
        chk("bp_alu_ord", 64'(e),
            64'({4'(ae), 32'hA000_0000 + ae}));
        ae++;
      end else begin
        chk("bp_lsb_ord", 64'(e),
            64'({4'(le), 32'hB000_0000 + le}));
        le++;
      end
    end
    chk("bp_alu_n", 64'(ae), 64'd10);
    chk("bp_lsb_n", 64'(le), 64'd10);

    // stall with two queued results
    reset_dut();
    alu(32'h21, 4'd1);
    lsb(32'h22, 4'd2);
    tick();
    idle_in();
    rdy = 1'b0;
    alu(32'hDEAD, 4'd9);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_send", 64'(bus.cdb_send), 64'd0);
    end
    idle_in();
    rdy = 1'b1;
    tick();
    exp_bus("stall_r1", 1'b1, 32'h21, 4'd1);
    tick();
    exp_bus("stall_r2", 1'b1, 32'h22, 4'd2);
    tick();
    exp_bus("stall_end", 1'b0, 32'h0, 4'd0);

    // flush with queued entries and a same-cycle push
    reset_dut();
    base = bcast.size();
    alu(32'h31, 4'd1);
    lsb(32'h41, 4'd2);
    tick();
    alu(32'h32, 4'd3);
    lsb(32'h42, 4'd4);
    tick();
    idle_in();
    alu(32'h33, 4'd5);
    tick();
    idle_in();
    jump_rst = 1'b1;
    alu(32'h55, 4'd6);
    tick();
    idle_in();
    jump_rst = 1'b0;
    chk("fl_send", 64'(bus.cdb_send), 64'd0);
    chk("fl_afull", 64'(bus.alu_full), 64'd0);
    chk("fl_lfull", 64'(bus.lsb_full), 64'd0);
    repeat (5) tick();
    chk("fl_count", 64'(bcast.size() - base), 64'd2);
    if (bcast.size() - base >= 2) begin
      chk("fl_b0", 64'(bcast[base]),
          64'({4'd1, 32'h31}));
      chk("fl_b1", 64'(bcast[base + 1]),
          64'({4'd2, 32'h41}));
    end

    // async reset while broadcasting
    reset_dut();
    alu(32'h66, 4'd6);
    tick();
    idle_in();
    tick();
    exp_bus("ar_pre", 1'b1, 32'h66, 4'd6);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_send", 64'(bus.cdb_send), 64'd0);
    chk("ar_val", 64'(bus.cdb_value), 64'd0);
    chk("ar_tag", 64'(bus.cdb_reorder), 64'd0);
    rst = 1'b0;
    alu(32'h77, 4'd7);
    tick();
    idle_in();
    exp_bus("ar_e1", 1'b0, 32'h0, 4'd0);
    tick();
    exp_bus("ar_e2", 1'b1, 32'h77, 4'd7);
    tick();
    exp_bus("ar_end", 1'b0, 32'h0, 4'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
